// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared state encoding and reset PC for the instruction-fetch stage
package if_fetch_pkg;
  localparam logic [31:0] IF_RESET_PC = 32'h0;
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4, VALID = 3'd5} if_state_t;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: fetches one 32-bit instruction as four byte reads and holds {pc, inst, valid} until IF_ID accepts
//   clk_in        rising-edge clock
//   rst_in        asynchronous active-low reset
//   stall_in      IF_ID cannot accept this cycle
//   jump_in       redirect request from EX, overrides grant and stall
//   jumpAddr_in   redirect target, used unaligned as given
//   memGrant_in   bus granted to IF this cycle
//   memData_in    byte for the address driven in the previous cycle
//   memReq_out    bus request (issue states S0..S3)
//   memAddr_out   byte address pc + k in state Sk
//   pc_out        PC of the held instruction
//   inst_out      held instruction, little-endian assembled
//   instValid_out pc_out/inst_out are valid
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        jump_in,
  input  logic [31:0] jumpAddr_in,
  input  logic        memGrant_in,
  input  logic [7:0]  memData_in,
  output logic        memReq_out,
  output logic [31:0] memAddr_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        instValid_out
);
  if_state_t   r_state;
  logic [31:0] r_pc;
  logic [7:0]  r_buf [0:2];
  logic [1:0]  w_k;
  // Issue states are encoded 0..3, so the low state bits are the byte offset.
  assign w_k         = r_state[1:0];
  assign memReq_out  = r_state inside {S0, S1, S2, S3};
  assign memAddr_out = r_pc + {30'd0, w_k};
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S0;
      r_pc          <= RESET_PC;
      r_buf[0]      <= 8'd0;
      r_buf[1]      <= 8'd0;
      r_buf[2]      <= 8'd0;
      inst_out      <= 32'd0;
      pc_out        <= 32'd0;
      instValid_out <= 1'b0;
    end else if (jump_in) begin
      r_pc          <= jumpAddr_in;
      r_state       <= S0;
      instValid_out <= 1'b0;
    end else begin
      case (r_state)
        S0: r_state <= memGrant_in ? S1 : S0;
        S1, S2, S3: begin
          // Byte for pc+(k-1) arrives now; a lost grant restarts the whole fetch.
          r_buf[w_k - 2'd1] <= memData_in;
          r_state           <= memGrant_in ? if_state_t'(r_state + 3'd1) : S0;
        end
        S4: begin
          inst_out      <= {memData_in, r_buf[2], r_buf[1], r_buf[0]};
          pc_out        <= r_pc;
          instValid_out <= 1'b1;
          r_state       <= VALID;
        end
        VALID: if (!stall_in) begin
          r_pc          <= r_pc + 32'd4;
          r_state       <= S0;
          instValid_out <= 1'b0;
        end
        default: r_state <= S0;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed self-checking bench for if_fetch
module tb_if_fetch;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        jump_in = 1'b0;
  logic [31:0] jumpAddr_in = 32'd0;
  logic        memGrant_in = 1'b1;
  logic [7:0]  memData_in = 8'd0;
  logic        memReq_out;
  logic [31:0] memAddr_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        instValid_out;
  logic [7:0]  mem [0:4095];
  int checks = 0;
  int failures = 0;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .jump_in(jump_in),
    .jumpAddr_in(jumpAddr_in), .memGrant_in(memGrant_in), .memData_in(memData_in),
    .memReq_out(memReq_out), .memAddr_out(memAddr_out), .pc_out(pc_out),
    .inst_out(inst_out), .instValid_out(instValid_out)
  );

  always #5 clk_in = ~clk_in;

  // Bus model: byte appears the cycle after a granted request; 0xEE otherwise.
  always @(posedge clk_in)
    memData_in <= (memReq_out && memGrant_in) ? mem[memAddr_out[11:0]] : 8'hEE;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem[3], mem[2], mem[1], mem[0]} = 32'h00100513;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h00200593;
    {mem[11], mem[10], mem[9], mem[8]} = 32'h00300613;
    {mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} = 32'h00c586b3;
    {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]} = 32'h00001237;
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    #12;
    chk("rst_valid", {31'd0, instValid_out}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_req", {31'd0, memReq_out}, 32'd1);
    chk("rst_addr", memAddr_out, 32'd0);
    rst_in = 1'b1;
    // Basic fetch at pc=0
    chk("f0_addr0", memAddr_out, 32'd0);
    tick(); chk("f0_addr1", memAddr_out, 32'd1);
    tick(); chk("f0_addr2", memAddr_out, 32'd2);
    tick(); chk("f0_addr3", memAddr_out, 32'd3);
    tick(); chk("f0_s4_req", {31'd0, memReq_out}, 32'd0);
    chk("f0_s4_valid", {31'd0, instValid_out}, 32'd0);
    tick(); chk("f0_valid", {31'd0, instValid_out}, 32'd1);
    chk("f0_inst", inst_out, 32'h00100513);
    chk("f0_pc", pc_out, 32'd0);
    tick(); chk("f1_addr", memAddr_out, 32'd4);
    chk("f1_valid0", {31'd0, instValid_out}, 32'd0);
    // Fetch at pc=4 with stall held for 3 VALID cycles
    stall_in = 1'b1;
    tick(5); chk("st_valid", {31'd0, instValid_out}, 32'd1);
    chk("st_inst", inst_out, 32'h00200593);
    chk("st_pc", pc_out, 32'd4);
    tick(2); chk("st_hold_valid", {31'd0, instValid_out}, 32'd1);
    chk("st_hold_inst", inst_out, 32'h00200593);
    chk("st_hold_pc", pc_out, 32'd4);
    chk("st_hold_req", {31'd0, memReq_out}, 32'd0);
    stall_in = 1'b0;
    tick(); chk("st_next_addr", memAddr_out, 32'd8);
    chk("st_next_req", {31'd0, memReq_out}, 32'd1);
    // Grant dropped for 2 cycles in S2 of pc=8
    tick(2); chk("gd_s2_addr", memAddr_out, 32'd10);
    memGrant_in = 1'b0;
    tick(); chk("gd_restart", memAddr_out, 32'd8);
    tick(); chk("gd_wait", memAddr_out, 32'd8);
    chk("gd_wait_req", {31'd0, memReq_out}, 32'd1);
    memGrant_in = 1'b1;
    tick(); chk("gd_addr9", memAddr_out, 32'd9);
    tick(); chk("gd_addr10", memAddr_out, 32'd10);
    tick(); chk("gd_addr11", memAddr_out, 32'd11);
    tick(2); chk("gd_valid", {31'd0, instValid_out}, 32'd1);
    chk("gd_inst", inst_out, 32'h00300613);
    chk("gd_pc", pc_out, 32'd8);
    tick(); chk("gd_next", memAddr_out, 32'd12);
    // Jump while in S2 of pc=12
    tick(2);
    jump_in = 1'b1; jumpAddr_in = 32'h100;
    tick(); jump_in = 1'b0;
    chk("js2_addr", memAddr_out, 32'h100);
    chk("js2_valid", {31'd0, instValid_out}, 32'd0);
    tick(5); chk("js2_valid1", {31'd0, instValid_out}, 32'd1);
    chk("js2_inst", inst_out, 32'h00c586b3);
    chk("js2_pc", pc_out, 32'h100);
    // Jump in VALID with stall=0 drops the held instruction
    jump_in = 1'b1; jumpAddr_in = 32'h200;
    tick(); jump_in = 1'b0;
    chk("jv_addr", memAddr_out, 32'h200);
    chk("jv_valid", {31'd0, instValid_out}, 32'd0);
    tick(5); chk("jv_inst", inst_out, 32'h00001237);
    chk("jv_pc", pc_out, 32'h200);
    tick(); chk("jv_next", memAddr_out, 32'h204);
    // Reset asserted during S3
    tick(3); chk("rs_s3_addr", memAddr_out, 32'h207);
    rst_in = 1'b0; #1;
    chk("rs_valid", {31'd0, instValid_out}, 32'd0);
    chk("rs_inst", inst_out, 32'd0);
    chk("rs_pc", pc_out, 32'd0);
    chk("rs_addr", memAddr_out, 32'd0);
    tick(); rst_in = 1'b1;
    chk("rs_rel_addr", memAddr_out, 32'd0);
    tick(5); chk("rs_inst2", inst_out, 32'h00100513);
    chk("rs_valid2", {31'd0, instValid_out}, 32'd1);
    // Misaligned jump that wraps past 2^32
    jump_in = 1'b1; jumpAddr_in = 32'hFFFF_FFFE;
    tick(); jump_in = 1'b0;
    chk("wr_addr0", memAddr_out, 32'hFFFF_FFFE);
    tick(); chk("wr_addr1", memAddr_out, 32'hFFFF_FFFF);
    tick(); chk("wr_addr2", memAddr_out, 32'h0);
    tick(); chk("wr_addr3", memAddr_out, 32'h1);
    tick(2); chk("wr_inst", inst_out, 32'h05132211);
    chk("wr_pc", pc_out, 32'hFFFF_FFFE);
    tick(); chk("wr_next", memAddr_out, 32'h2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
